minhash_sched: RTL and testbench

Sequencer for the MinHash Jaccard datapath: two hash instances, two min-reduction instances and the match counter. For each of NUM_HASH hash functions it:
- fetches a seed pair (randA, randB) from an external seed table,
- drives the pair into both hash instances,
- waits the datapath latency,
- compares the two per-sequence minima and accumulates matches.

It also holds the k-mer inputs stable while busy and reports the final match count as jaccardSimilarity with a done pulse.

---
 rtl/minhash_pkg.sv | 23 ++
 rtl/minhash_wait_timer.sv | 42 ++++
 rtl/minhash_sched.sv | 189 ++++++++++++++++++
 tb/tb_minhash_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/minhash_pkg.sv
// Shared types and constants for the MinHash Jaccard sequencer.
package minhash_pkg;

  localparam int unsigned DEFAULT_SEED_W = 32;
  localparam int unsigned DEFAULT_CNT_W  = 5;
  localparam int unsigned WAIT_W         = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT,
    COMPARE,
    DONE
  } sched_state_t;

  // Cycles from start acceptance to the done pulse for a full comparison.
  function automatic int unsigned run_latency(input int unsigned num_hash,
                                              input int unsigned pipe_lat);
    return num_hash * (pipe_lat + 32'd3) + 32'd1;
  endfunction

endpackage

// File: rtl/minhash_wait_timer.sv
// Loadable down-counter that covers the datapath latency in WAIT.
// expired_o is high whenever the count is 1 or less.
module minhash_wait_timer
  import minhash_pkg::*;
#(
  parameter int unsigned W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         expired_q;

  // Next count: load wins over decrement; hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register and registered expiry flag tracking the new count.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q     <= '0;
      expired_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d <= W'(1));
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/minhash_sched.sv
// Sequencer for the MinHash Jaccard datapath: fetches seed pairs, waits
// the hash/min latency, and counts matching per-sequence minima.
// Optional: define MINHASH_SCHED_PERF_EN to add the runCycles counter.
module minhash_sched
  import minhash_pkg::*;
#(
  parameter int unsigned NUM_HASH = 20,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned SEED_W   = DEFAULT_SEED_W,
  parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
  input  logic                                             clk,
  input  logic                                             rstN,
  input  logic                                             start,
  output logic                                             busy,
  output logic                                             kmerHold,
  output logic [((NUM_HASH > 1) ? $clog2(NUM_HASH) : 1)-1:0] seedAddr,
  input  logic [SEED_W-1:0]                                seedA,
  input  logic [SEED_W-1:0]                                seedB,
  output logic [SEED_W-1:0]                                randA,
  output logic [SEED_W-1:0]                                randB,
  input  logic [SEED_W-1:0]                                minValSeqOne,
  input  logic [SEED_W-1:0]                                minValSeqTwo,
  output logic [CNT_W-1:0]                                 jaccardSimilarity,
  output logic                                             done
`ifdef MINHASH_SCHED_PERF_EN
  ,
  output logic [15:0]                                      runCycles
`endif
);

  localparam int unsigned AW = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;
  localparam logic [AW-1:0]     LAST_IDX = AW'(NUM_HASH - 1);
  localparam logic [WAIT_W-1:0] LAT_V    = WAIT_W'(PIPE_LAT);

  // Elaboration-time parameter range checks.
  if ((NUM_HASH < 1) || (NUM_HASH > (2 ** CNT_W) - 1)) begin : g_bad_num_hash
    $error("minhash_sched: NUM_HASH must be 1..2**CNT_W-1");
  end
  if (PIPE_LAT > 15) begin : g_bad_pipe_lat
    $error("minhash_sched: PIPE_LAT must be 0..15");
  end

  sched_state_t      state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]  match_q, match_d;
  logic [CNT_W-1:0]  jac_q, jac_d;
  logic [SEED_W-1:0] rand_a_q, rand_a_d;
  logic [SEED_W-1:0] rand_b_q, rand_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tmr_load, tmr_dec, tmr_expired;

  minhash_wait_timer #(
    .W (WAIT_W)
  ) u_wait_timer (
    .clk        (clk),
    .rst_i      (rstN),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (LAT_V),
    .expired_o  (tmr_expired)
  );

  // Next-state and registered-output logic for the sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    match_d  = match_q;
    jac_d    = jac_q;
    rand_a_d = rand_a_q;
    rand_b_d = rand_b_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          idx_d   = '0;
          match_d = '0;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        rand_a_d = seedA;
        rand_b_d = seedB;
        tmr_load = 1'b1;
        state_d  = (LAT_V != '0) ? WAIT : COMPARE;
      end
      WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_expired) begin
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (minValSeqOne == minValSeqTwo) begin
          match_d = match_q + CNT_W'(1);
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          jac_d   = match_d;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rstN) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      match_q  <= '0;
      jac_q    <= '0;
      rand_a_q <= '0;
      rand_b_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      match_q  <= match_d;
      jac_q    <= jac_d;
      rand_a_q <= rand_a_d;
      rand_b_q <= rand_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy              = busy_q;
  assign kmerHold          = busy_q;
  assign seedAddr          = idx_q;
  assign randA             = rand_a_q;
  assign randB             = rand_b_q;
  assign jaccardSimilarity = jac_q;
  assign done              = done_q;

`ifdef MINHASH_SCHED_PERF_EN
  logic [15:0] perf_cnt_q, perf_cnt_d;
  logic [15:0] run_cycles_q, run_cycles_d;
  logic [15:0] perf_inc;

  // Busy-cycle counter (1 in the first busy cycle), latched entering DONE.
  always_comb begin
    perf_inc     = (perf_cnt_q == 16'hFFFF) ? 16'hFFFF : (perf_cnt_q + 16'd1);
    perf_cnt_d   = perf_cnt_q;
    run_cycles_d = run_cycles_q;
    if (state_q == IDLE) begin
      if (start) begin
        perf_cnt_d = 16'd1;
      end
    end else begin
      perf_cnt_d = perf_inc;
    end
    if (state_d == DONE) begin
      run_cycles_d = perf_inc;
    end
  end

  // Performance counter registers; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rstN) begin
      perf_cnt_q   <= '0;
      run_cycles_q <= '0;
    end else begin
      perf_cnt_q   <= perf_cnt_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign runCycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_minhash_sched.sv
// Scoreboard bench for minhash_sched (20 hashes, latency 3) plus a
// single-hash, zero-latency instance.
module tb_minhash_sched;
  import minhash_pkg::*;

  localparam int NH   = 20;
  localparam int PL   = 3;
  localparam int PH   = PL + 3;
  localparam int RLAT = 121;
  localparam int SLAT = 4;

  typedef struct {
    int unsigned jac;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        start = 1'b0;
  logic        busy, kmerHold, done;
  logic [4:0]  seedAddr;
  logic [31:0] seedA = '0, seedB = '0;
  logic [31:0] randA, randB, minOne, minTwo;
  logic [4:0]  jac;
  logic [31:0] match_mask = '0;

  logic        start_s = 1'b0;
  logic        busy_s, kmerHold_s, done_s;
  logic [0:0]  seedAddr_s;
  logic [31:0] seedA_s = '0, seedB_s = '0;
  logic [31:0] randA_s, randB_s;
  logic [4:0]  jac_s;
  logic [31:0] minOne_s = 32'd0;
  logic [31:0] minTwo_s = 32'd1;
`ifdef MINHASH_SCHED_PERF_EN
  logic [15:0] runCycles, runCycles_s;
`endif

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  minhash_sched #(.NUM_HASH(NH), .PIPE_LAT(PL), .SEED_W(32), .CNT_W(5)) dut (
    .clk(clk), .rstN(rstN), .start(start), .busy(busy), .kmerHold(kmerHold),
    .seedAddr(seedAddr), .seedA(seedA), .seedB(seedB), .randA(randA), .randB(randB),
    .minValSeqOne(minOne), .minValSeqTwo(minTwo), .jaccardSimilarity(jac), .done(done)
`ifdef MINHASH_SCHED_PERF_EN
    , .runCycles(runCycles)
`endif
  );

  minhash_sched #(.NUM_HASH(1), .PIPE_LAT(0), .SEED_W(32), .CNT_W(5)) dut_s (
    .clk(clk), .rstN(rstN), .start(start_s), .busy(busy_s), .kmerHold(kmerHold_s),
    .seedAddr(seedAddr_s), .seedA(seedA_s), .seedB(seedB_s), .randA(randA_s),
    .randB(randB_s), .minValSeqOne(minOne_s), .minValSeqTwo(minTwo_s),
    .jaccardSimilarity(jac_s), .done(done_s)
`ifdef MINHASH_SCHED_PERF_EN
    , .runCycles(runCycles_s)
`endif
  );

  function automatic logic [31:0] tbl_a(input int i);
    return 32'hA5C3_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] tbl_b(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Seed table with one cycle of read latency.
  always @(posedge clk) begin
    seedA   <= tbl_a(int'(seedAddr));
    seedB   <= tbl_b(int'(seedAddr));
    seedA_s <= tbl_a(int'(seedAddr_s));
    seedB_s <= tbl_b(int'(seedAddr_s));
  end

  // Datapath stand-in: minima agree only for hash indices set in match_mask.
  always_comb begin
    minOne = randA;
    minTwo = match_mask[randA[4:0]] ? randA : ~randA;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("jaccard", 32'(jac), e.jac);
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
`ifdef MINHASH_SCHED_PERF_EN
        chk("runCycles", 32'(runCycles), 32'(RLAT));
`endif
      end
    end
  end

  task automatic run(input logic [31:0] mask, input int unsigned exp_jac, input bit extra);
    int c;
    int i;
    match_mask = mask;
    @(negedge clk);
    c = cyc;
    start = 1'b1;
    sb.push_back('{jac: exp_jac, cyc: c + RLAT});
    for (int k = 1; k <= RLAT + 1; k++) begin
      @(negedge clk);
      start = extra && (k == 10 || k == RLAT);
      chk("busy", 32'(busy), 32'(k <= RLAT));
      chk("kmerHold", 32'(kmerHold), 32'(busy));
      if (k >= 3 && k <= RLAT) begin
        i = (k - 3) / PH;
        if (i > NH - 1) i = NH - 1;
        chk("randA", randA, tbl_a(i));
        chk("randB", randB, tbl_b(i));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int c;
    if (run_latency(NH, PL) != RLAT || run_latency(1, 0) != SLAT)
      $display("note: latency constants disagree with package helper");

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_randA", randA, 32'd0);
    chk("rst_randB", randB, 32'd0);
    chk("rst_jac", 32'(jac), 32'd0);
    chk("rst_seedAddr", 32'(seedAddr), 32'd0);
    rstN = 1'b0;

    // Single hash, zero latency, minima differ.
    @(negedge clk);
    c = cyc;
    start_s = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start_s = 1'b0;
      chk("s_done", 32'(done_s), 32'(k == SLAT));
      chk("s_busy", 32'(busy_s), 32'(k <= SLAT));
      chk("s_hold", 32'(kmerHold_s), 32'(k <= SLAT));
      if (k == SLAT) begin
        chk("s_jac", 32'(jac_s), 32'd0);
        chk("s_randA", randA_s, tbl_a(0));
        chk("s_randB", randB_s, tbl_b(0));
`ifdef MINHASH_SCHED_PERF_EN
        chk("s_runCycles", 32'(runCycles_s), 32'(SLAT));
`endif
      end
    end
    chk("s_cyc", 32'(cyc - c), 32'd6);

    // All minima match; stray starts at cycles 10 and 121 are ignored.
    run(32'hFFFF_FFFF, 20, 1'b1);
    // Matches only at indices 0, 5, 19.
    run(32'h0008_0021, 3, 1'b0);

    // Start held high: second run accepted in the cycle after DONE.
    match_mask = 32'h0000_00F0;
    @(negedge clk);
    c = cyc;
    start = 1'b1;
    sb.push_back('{jac: 4, cyc: c + RLAT});
    sb.push_back('{jac: 4, cyc: c + RLAT + 1 + RLAT});
    for (int k = 1; k <= 2 * RLAT + 6; k++) begin
      @(negedge clk);
      if (k == RLAT + 2) start = 1'b0;
      if (k == RLAT + 1) chk("held_idle_busy", 32'(busy), 32'd0);
      if (k == RLAT + 2) chk("held_rerun_busy", 32'(busy), 32'd1);
    end

    // Reset mid-run: no done pulse, everything cleared.
    match_mask = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 51; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 50) rstN = 1'b1;
      if (k == 51) begin
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_hold", 32'(kmerHold), 32'd0);
        chk("mrst_randA", randA, 32'd0);
        chk("mrst_randB", randB, 32'd0);
        chk("mrst_jac", 32'(jac), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        rstN = 1'b0;
      end
    end
    repeat (RLAT + 20) @(negedge clk);
    chk("mrst_still_idle", 32'(busy), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
